// File: rtl/vga_multi_ball.sv
// vga_multi_ball: 640x480 VGA raster generator that draws up to NUM_BALLS
// circular sprites over a programmable background colour.
//
// Ports
//   clk, reset           50 MHz system clock, asynchronous active-high reset
//   chipselect, write    CPU register bus strobes (write=0 with chipselect=1 is a read)
//   address, writedata   register address and write data
//   readdata             registered read data, updated one clk after a read request
//   VGA_R/G/B            8-bit colour, forced to 0 outside the active region
//   VGA_CLK              pixel clock (hcount[0])
//   VGA_HS, VGA_VS       active-low sync, delayed one clk to line up with the colour
//   VGA_BLANK_n          high during the active region, same one-clk delay
//   VGA_SYNC_n           tied low
//
// Register map: 0/1/2 background R/G/B, 3 control (bit0 requests a commit),
// 4 hcount, 5 vcount, 6 frame count, 7 status {vblank, commit_pending},
// 8+3i / 9+3i / 10+3i ball i X / Y / attr ([15] enable, [11:0] RGB444).
//
// Bus handshake: a transfer happens in every clk where chipselect=1; there is
// no back-pressure. Writes take effect at that clk edge; reads land in
// readdata at that edge and readdata holds until the next read.
`timescale 1ns/1ps
module vga_multi_ball #(
    parameter int NUM_BALLS = 4,
    parameter int BALL_SIZE = 64,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic              VGA_CLK,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_n,
    output logic              VGA_SYNC_n
);
    localparam int          RADIUS = BALL_SIZE / 2;
    localparam logic [12:0] R13    = 13'(RADIUS);
    localparam logic [25:0] R_SQ   = 26'(RADIUS * RADIUS);

    // Raster counters
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        end_of_line, end_of_frame, vblank_start, vblank, active;
    logic [9:0]  column;

    assign end_of_line  = (hcount == 11'd1599);
    assign end_of_frame = (vcount == 10'd524);
    assign vblank_start = (hcount == 11'd0) && (vcount == 10'd480);
    assign vblank       = (vcount >= 10'd480);
    assign active       = (hcount < 11'd1280) && (vcount < 10'd480);
    assign column       = hcount[10:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (end_of_line) begin
            hcount <= '0;
            vcount <= end_of_frame ? 10'd0 : vcount + 10'd1;
        end else begin
            hcount <= hcount + 11'd1;
        end
    end

    // Register file
    logic        bus_wr, bus_rd;
    logic [7:0]  bg_r, bg_g, bg_b;
    logic        commit_pending;
    logic [15:0] frame_count;
    logic [9:0]  sh_x [NUM_BALLS];
    logic [9:0]  sh_y [NUM_BALLS];
    logic [15:0] sh_attr [NUM_BALLS];
    logic [9:0]  act_x [NUM_BALLS];
    logic [9:0]  act_y [NUM_BALLS];
    logic [12:0] act_attr [NUM_BALLS];   // {enable, RGB444}

    assign bus_wr = chipselect & write;
    assign bus_rd = chipselect & ~write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bg_r           <= 8'h00;
            bg_g           <= 8'h00;
            bg_b           <= 8'h80;
            commit_pending <= 1'b0;
            frame_count    <= '0;
            // Ball i rests at 100*(i+1), so ball 0 starts at (100,100).
            // Indices whose position exceeds 10 bits simply truncate; they are
            // disabled at reset anyway.
            for (int i = 0; i < NUM_BALLS; i++) begin
                sh_x[i]     <= 10'(100 * (i + 1));
                sh_y[i]     <= 10'(100 * (i + 1));
                sh_attr[i]  <= (i == 0) ? 16'h8FFF : 16'h0000;
                act_x[i]    <= 10'(100 * (i + 1));
                act_y[i]    <= 10'(100 * (i + 1));
                act_attr[i] <= (i == 0) ? 13'h1FFF : 13'h0000;
            end
        end else begin
            if (bus_wr && address == ADDR_W'(0)) bg_r <= writedata[7:0];
            if (bus_wr && address == ADDR_W'(1)) bg_g <= writedata[7:0];
            if (bus_wr && address == ADDR_W'(2)) bg_b <= writedata[7:0];

            // A fresh request in the commit cycle wins over the clear, so it
            // is honoured at the following vblank start.
            if (bus_wr && address == ADDR_W'(3) && writedata[0])
                commit_pending <= 1'b1;
            else if (vblank_start)
                commit_pending <= 1'b0;

            if (vblank_start)
                frame_count <= frame_count + 16'd1;

            // Non-blocking copy: a shadow write in this same clk is not seen,
            // it waits in shadow for the next commit.
            if (vblank_start && commit_pending) begin
                for (int i = 0; i < NUM_BALLS; i++) begin
                    act_x[i]    <= sh_x[i];
                    act_y[i]    <= sh_y[i];
                    act_attr[i] <= {sh_attr[i][15], sh_attr[i][11:0]};
                end
            end

            for (int i = 0; i < NUM_BALLS; i++) begin
                if (bus_wr && address == ADDR_W'(8 + 3 * i))  sh_x[i]    <= writedata[9:0];
                if (bus_wr && address == ADDR_W'(9 + 3 * i))  sh_y[i]    <= writedata[9:0];
                if (bus_wr && address == ADDR_W'(10 + 3 * i)) sh_attr[i] <= writedata;
            end
        end
    end

    // Read mux; ball registers read back their shadow copies
    logic [15:0] rd_value;

    always_comb begin
        rd_value = '0;
        case (address)
            ADDR_W'(0): rd_value = {8'h00, bg_r};
            ADDR_W'(1): rd_value = {8'h00, bg_g};
            ADDR_W'(2): rd_value = {8'h00, bg_b};
            ADDR_W'(3): rd_value = {15'h0000, commit_pending};
            ADDR_W'(4): rd_value = {5'h00, hcount};
            ADDR_W'(5): rd_value = {6'h00, vcount};
            ADDR_W'(6): rd_value = frame_count;
            ADDR_W'(7): rd_value = {14'h0000, vblank, commit_pending};
            default:    rd_value = '0;
        endcase
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (address == ADDR_W'(8 + 3 * i))  rd_value = {6'h00, sh_x[i]};
            if (address == ADDR_W'(9 + 3 * i))  rd_value = {6'h00, sh_y[i]};
            if (address == ADDR_W'(10 + 3 * i)) rd_value = sh_attr[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       readdata <= '0;
        else if (bus_rd) readdata <= rd_value;
    end

    // Hit test. Offsets are 13-bit two's complement, wide enough for any
    // 10-bit position plus radius. Squares are taken modulo 2^26 on the
    // sign-extended offsets, which equals the true square since it is < 2^26.
    logic [12:0]          dx [NUM_BALLS];
    logic [12:0]          dy [NUM_BALLS];
    logic [25:0]          dist_sq [NUM_BALLS];
    logic [NUM_BALLS-1:0] hit;
    logic [23:0]          pix_color;

    always_comb begin
        for (int i = 0; i < NUM_BALLS; i++) begin
            dx[i]      = {3'b000, column} - {3'b000, act_x[i]} - R13;
            dy[i]      = {3'b000, vcount} - {3'b000, act_y[i]} - R13;
            dist_sq[i] = {{13{dx[i][12]}}, dx[i]} * {{13{dx[i][12]}}, dx[i]}
                       + {{13{dy[i][12]}}, dy[i]} * {{13{dy[i][12]}}, dy[i]};
            hit[i]     = act_attr[i][12] && (dist_sq[i] <= R_SQ);
        end
    end

    // Walk from the top index down so the lowest hitting index lands last.
    always_comb begin
        pix_color = {bg_r, bg_g, bg_b};
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (hit[i])
                pix_color = {{2{act_attr[i][11:8]}}, {2{act_attr[i][7:4]}}, {2{act_attr[i][3:0]}}};
        end
    end

    // Output stage: colour and syncs share the same one-clk delay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {VGA_R, VGA_G, VGA_B} <= '0;
            VGA_BLANK_n           <= 1'b0;
            VGA_HS                <= 1'b1;
            VGA_VS                <= 1'b1;
        end else begin
            {VGA_R, VGA_G, VGA_B} <= active ? pix_color : 24'h000000;
            VGA_BLANK_n           <= active;
            VGA_HS                <= !((hcount >= 11'd1312) && (hcount <= 11'd1503));
            VGA_VS                <= !((vcount >= 10'd490) && (vcount <= 10'd491));
        end
    end

    assign VGA_CLK    = hcount[0];
    assign VGA_SYNC_n = 1'b0;

endmodule

// File: tb/tb_vga_multi_ball.sv
`timescale 1ns/1ps
module tb_vga_multi_ball;
  localparam int NUM_BALLS = 4;
  localparam int BALL_SIZE = 64;
  localparam int ADDR_W    = 5;

  localparam logic [23:0] BG    = 24'h000080;
  localparam logic [23:0] WHITE = 24'hFFFFFF;

  typedef struct {
    int          col;
    int          row;
    logic [23:0] rgb;
  } pt_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  logic              chipselect, write;
  logic [ADDR_W-1:0] address;
  logic [15:0]       writedata, readdata;
  logic [7:0]        vga_r, vga_g, vga_b;
  logic              vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;

  vga_multi_ball #(.NUM_BALLS(NUM_BALLS), .BALL_SIZE(BALL_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b), .VGA_CLK(vga_clk),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_BLANK_n(vga_blank_n), .VGA_SYNC_n(vga_sync_n)
  );

  // scoreboard
  logic [23:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_frames;
  logic [10:0] jump_h;
  logic [9:0]  jump_v;

  // driver tasks
  // Move the raster to (h,v) at a falling edge; the next rising edge renders it.
  task jump(input int h, input int v);
    @(negedge clk);
    jump_h = 11'(h);
    jump_v = 10'(v);
    force dut.hcount = jump_h;
    force dut.vcount = jump_v;
    release dut.hcount;
    release dut.vcount;
  endtask

  task bus_write(input int a, input int d);
    @(negedge clk);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = ADDR_W'(a);
    writedata  = 16'(d);
    @(negedge clk);
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task bus_read(input int a, output logic [15:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write      = 1'b0;
    address    = ADDR_W'(a);
    @(negedge clk);
    chipselect = 1'b0;
    d          = readdata;
  endtask

  task probe(input int col, input int row, output logic [23:0] rgb, output logic blank_n);
    jump(2 * col, row);
    @(posedge clk);
    #1;
    rgb     = {vga_r, vga_g, vga_b};
    blank_n = vga_blank_n;
  endtask

  // Land on the last pixel of line 479; two edges later the commit/frame tick is done.
  task frame_advance();
    jump(1599, 479);
    @(posedge clk);
    @(posedge clk);
    #1;
    exp_frames = exp_frames + 16'd1;
  endtask

  task automatic test_reset();
    logic [23:0] got, exp;
    logic        bl;
    logic [15:0] rd;
    pt_t         pts[8];
    pts = '{'{132, 132, WHITE}, '{100, 132, WHITE}, '{99, 132, BG}, '{132, 164, WHITE},
            '{132, 165, BG}, '{232, 232, BG}, '{332, 332, BG}, '{432, 432, BG}};
    reset = 1'b1;
    chipselect = 1'b0; write = 1'b0; address = '0; writedata = '0;
    exp_frames = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({vga_blank_n, vga_r, vga_g, vga_b} !== 25'd0) begin
      errors++; $display("FAIL reset_outputs: got %07h expected 0", {vga_blank_n, vga_r, vga_g, vga_b});
    end
    checks++;
    if (readdata !== 16'h0000) begin
      errors++; $display("FAIL reset_readdata: got %04h expected 0000", readdata);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back({1'b1, BG} & 24'hFFFFFF);
    exp = exp_q.pop_front();
    checks++;
    if (vga_blank_n !== 1'b1 || {vga_r, vga_g, vga_b} !== exp) begin
      errors++; $display("FAIL first_pixel: got blank_n=%b rgb=%06h expected 1 %06h", vga_blank_n, {vga_r, vga_g, vga_b}, exp);
    end
    foreach (pts[k]) exp_q.push_back(pts[k].rgb);
    foreach (pts[k]) begin
      probe(pts[k].col, pts[k].row, got, bl);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL reset_pixel(%0d,%0d): got %06h expected %06h", pts[k].col, pts[k].row, got, exp);
      end
    end
    exp_q.push_back(24'(exp_frames));
    bus_read(6, rd);
    exp = exp_q.pop_front();
    checks++;
    if (24'(rd) !== exp) begin
      errors++; $display("FAIL reset_frame_count: got %04h expected %04h", rd, exp[15:0]);
    end
  endtask

  task automatic test_shadow();
    logic [23:0] got, exp;
    logic        bl;
    logic [15:0] rd;
    pt_t         moved[4];
    moved = '{'{332, 132, WHITE}, '{300, 132, WHITE}, '{299, 132, BG}, '{132, 132, BG}};
    bus_write(8, 300);
    for (int f = 0; f < 3; f++) begin
      if (f > 0) frame_advance();
      exp_q.push_back(WHITE);
      exp_q.push_back(BG);
      probe(132, 132, got, bl);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL shadow_hold_old f%0d: got %06h expected %06h", f, got, exp);
      end
      probe(332, 132, got, bl);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL shadow_hold_new f%0d: got %06h expected %06h", f, got, exp);
      end
    end
    // status mid-frame: no request yet, then request, then a 0 write is ignored
    exp_q.push_back(24'h0000);
    exp_q.push_back(24'h0001);
    exp_q.push_back(24'h0001);
    bus_read(7, rd);
    exp = exp_q.pop_front();
    checks++;
    if (24'(rd) !== exp) begin errors++; $display("FAIL status_idle: got %04h expected %04h", rd, exp[15:0]); end
    bus_write(3, 1);
    bus_read(7, rd);
    exp = exp_q.pop_front();
    checks++;
    if (24'(rd) !== exp) begin errors++; $display("FAIL status_pending: got %04h expected %04h", rd, exp[15:0]); end
    bus_write(3, 0);
    bus_read(7, rd);
    exp = exp_q.pop_front();
    checks++;
    if (24'(rd) !== exp) begin errors++; $display("FAIL status_write0: got %04h expected %04h", rd, exp[15:0]); end
    frame_advance();
    exp_q.push_back(24'h0002);
    bus_read(7, rd);
    exp = exp_q.pop_front();
    checks++;
    if (24'(rd) !== exp) begin errors++; $display("FAIL status_committed: got %04h expected %04h", rd, exp[15:0]); end
    foreach (moved[k]) exp_q.push_back(moved[k].rgb);
    foreach (moved[k]) begin
      probe(moved[k].col, moved[k].row, got, bl);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL moved_pixel(%0d,%0d): got %06h expected %06h", moved[k].col, moved[k].row, got, exp);
      end
    end
  endtask

  task automatic test_commit_race();
    logic [23:0] got, exp;
    logic        bl;
    logic [15:0] rd;
    bus_write(8, 200);
    bus_write(3, 1);
    // write X in the exact commit cycle
    jump(1599, 479);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = ADDR_W'(8); writedata = 16'd250;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
    exp_frames = exp_frames + 16'd1;
    exp_q.push_back(24'h0002);
    exp_q.push_back(WHITE);
    exp_q.push_back(BG);
    bus_read(7, rd);
    exp = exp_q.pop_front();
    checks++;
    if (24'(rd) !== exp) begin errors++; $display("FAIL race_status: got %04h expected %04h", rd, exp[15:0]); end
    probe(232, 132, got, bl);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL race_old_committed: got %06h expected %06h", got, exp); end
    probe(282, 132, got, bl);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL race_new_not_yet: got %06h expected %06h", got, exp); end
    bus_write(3, 1);
    frame_advance();
    exp_q.push_back(WHITE);
    exp_q.push_back(BG);
    probe(282, 132, got, bl);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL race_new_committed: got %06h expected %06h", got, exp); end
    probe(232, 132, got, bl);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL race_old_gone: got %06h expected %06h", got, exp); end
    // control request written in the commit cycle stays pending
    bus_write(8, 400);
    bus_write(3, 1);
    jump(1599, 479);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = ADDR_W'(3); writedata = 16'd1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
    exp_frames = exp_frames + 16'd1;
    exp_q.push_back(24'h0003);
    exp_q.push_back(WHITE);
    exp_q.push_back(24'd400);
    exp_q.push_back(24'h0002);
    bus_read(7, rd);
    exp = exp_q.pop_front();
    checks++;
    if (24'(rd) !== exp) begin errors++; $display("FAIL ctrl_race_status: got %04h expected %04h", rd, exp[15:0]); end
    probe(432, 132, got, bl);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL ctrl_race_pixel: got %06h expected %06h", got, exp); end
    bus_read(8, rd);
    exp = exp_q.pop_front();
    checks++;
    if (24'(rd) !== exp) begin errors++; $display("FAIL shadow_x_readback: got %04h expected %04h", rd, exp[15:0]); end
    frame_advance();
    bus_read(7, rd);
    exp = exp_q.pop_front();
    checks++;
    if (24'(rd) !== exp) begin errors++; $display("FAIL ctrl_race_cleared: got %04h expected %04h", rd, exp[15:0]); end
  endtask

  task automatic test_overlap();
    logic [23:0] got, exp;
    logic        bl;
    logic [15:0] rd;
    bus_write(8, 200);  bus_write(9, 200);  bus_write(10, 16'h8F00);
    bus_write(11, 200); bus_write(12, 200); bus_write(13, 16'h80F0);
    bus_write(3, 1);
    frame_advance();
    exp_q.push_back(24'hFF0000);
    exp_q.push_back(24'hFF0000);
    probe(232, 232, got, bl);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL overlap_centre: got %06h expected %06h", got, exp); end
    probe(200, 232, got, bl);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL overlap_edge: got %06h expected %06h", got, exp); end
    bus_write(10, 16'h0F00);
    bus_write(13, 16'h8A5C);
    bus_write(3, 1);
    frame_advance();
    exp_q.push_back(24'hAA55CC);
    exp_q.push_back(24'h8A5C);
    probe(232, 232, got, bl);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL nibble_replicate: got %06h expected %06h", got, exp); end
    bus_read(13, rd);
    exp = exp_q.pop_front();
    checks++;
    if (24'(rd) !== exp) begin errors++; $display("FAIL attr_readback: got %04h expected %04h", rd, exp[15:0]); end
    bus_write(13, 0);
    bus_write(3, 1);
    frame_advance();
  endtask

  task automatic test_frame_count();
    logic [23:0] exp;
    logic [15:0] rd, first;
    exp_q.push_back(24'(exp_frames));
    bus_read(6, first);
    exp = exp_q.pop_front();
    checks++;
    if (24'(first) !== exp) begin errors++; $display("FAIL frame_count_start: got %04h expected %04h", first, exp[15:0]); end
    repeat (3) frame_advance();
    exp_q.push_back(24'(exp_frames));
    bus_read(6, rd);
    exp = exp_q.pop_front();
    checks++;
    if (24'(rd) !== exp || 16'(rd - first) !== 16'd3) begin
      errors++; $display("FAIL frame_count_plus3: got %04h expected %04h", rd, exp[15:0]);
    end
    @(negedge clk);
    force dut.frame_count = 16'hFFFF;
    release dut.frame_count;
    exp_frames = 16'hFFFF;
    frame_advance();
    exp_q.push_back(24'(exp_frames));
    bus_read(6, rd);
    exp = exp_q.pop_front();
    checks++;
    if (24'(rd) !== exp) begin errors++; $display("FAIL frame_count_wrap: got %04h expected %04h", rd, exp[15:0]); end
    // counter readback samples the request cycle (one clk after the jump)
    jump(500, 200);
    exp_q.push_back(24'd501);
    exp_q.push_back(24'd200);
    bus_read(4, rd);
    exp = exp_q.pop_front();
    checks++;
    if (24'(rd) !== exp) begin errors++; $display("FAIL hcount_readback: got %04h expected %04h", rd, exp[15:0]); end
    bus_read(5, rd);
    exp = exp_q.pop_front();
    checks++;
    if (24'(rd) !== exp) begin errors++; $display("FAIL vcount_readback: got %04h expected %04h", rd, exp[15:0]); end
  endtask

  task automatic test_clip();
    logic [23:0] got, exp;
    logic        bl;
    int          lows;
    pt_t         pts[7];
    pts = '{'{639, 479, WHITE}, '{632, 470, WHITE}, '{620, 479, BG}, '{0, 479, BG},
            '{639, 0, BG}, '{0, 0, BG}, '{652, 479, 24'h000000}};
    bus_write(8, 620); bus_write(9, 460); bus_write(10, 16'h8FFF);
    bus_write(3, 1);
    frame_advance();
    foreach (pts[k]) exp_q.push_back(pts[k].rgb);
    foreach (pts[k]) begin
      probe(pts[k].col, pts[k].row, got, bl);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL clip_pixel(%0d,%0d): got %06h expected %06h", pts[k].col, pts[k].row, got, exp);
      end
    end
    checks++;
    if (bl !== 1'b0) begin errors++; $display("FAIL blank_outside: got %b expected 0", bl); end
    jump(1200, 100);
    lows = 0;
    repeat (400) begin @(posedge clk); #1; if (vga_hs === 1'b0) lows++; end
    exp_q.push_back(24'd192);
    exp = exp_q.pop_front();
    checks++;
    if (24'(lows) !== exp) begin errors++; $display("FAIL hs_width: got %0d expected %0d", lows, exp); end
    jump(1599, 488);
    lows = 0;
    repeat (8000) begin @(posedge clk); #1; if (vga_vs === 1'b0) lows++; end
    exp_q.push_back(24'd3200);
    exp = exp_q.pop_front();
    checks++;
    if (24'(lows) !== exp) begin errors++; $display("FAIL vs_width: got %0d expected %0d", lows, exp); end
  endtask

  task automatic test_reset_abort();
    logic [23:0] got, exp;
    logic        bl;
    logic [15:0] rd;
    jump(0, 100);
    bus_write(3, 1);
    exp_q.push_back(24'h0001);
    bus_read(7, rd);
    exp = exp_q.pop_front();
    checks++;
    if (24'(rd) !== exp) begin errors++; $display("FAIL abort_pending_before: got %04h expected %04h", rd, exp[15:0]); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_frames = 16'd0;
    exp_q.push_back(24'h0000);
    exp_q.push_back(24'd100);
    exp_q.push_back(WHITE);
    bus_read(7, rd);
    exp = exp_q.pop_front();
    checks++;
    if (24'(rd) !== exp) begin errors++; $display("FAIL abort_pending_cleared: got %04h expected %04h", rd, exp[15:0]); end
    bus_read(8, rd);
    exp = exp_q.pop_front();
    checks++;
    if (24'(rd) !== exp) begin errors++; $display("FAIL abort_x_reset: got %04h expected %04h", rd, exp[15:0]); end
    probe(132, 132, got, bl);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL abort_ball_home: got %06h expected %06h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_shadow();
    test_commit_race();
    test_overlap();
    test_frame_count();
    test_clip();
    test_reset_abort();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
